// File: rtl/vector_seq_pkg.sv
// ---------------------------------------------------------------------------
// vector_seq_pkg
// Shared definitions for the vector sequencer: FSM state encoding, operation
// codes and the memory write-data select value that picks R1 instead of an
// X1 byte.
// ---------------------------------------------------------------------------
package vector_seq_pkg;

    // Sequencer states. The element loops (RD/CAP and WR) are walked with a
    // separate 2-bit element index rather than unrolled states.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_BASE = 4'd1,
        S_XLD  = 4'd2,
        S_RD   = 4'd3,
        S_CAP  = 4'd4,
        S_WR   = 4'd5,
        S_TADD = 4'd6,
        S_VWR  = 4'd7,
        S_FIN  = 4'd8
    } state_t;

    localparam logic [1:0] OP_VLOAD  = 2'b00;
    localparam logic [1:0] OP_VSTORE = 2'b01;
    localparam logic [1:0] OP_VADD   = 2'b10;
    localparam logic [1:0] OP_ILL    = 2'b11;

    // MemIn 0..3 select X1 bytes [31:24]..[7:0]; 4 selects R1 (idle default).
    localparam logic [2:0] MEMIN_R1 = 3'd4;

    // Index of the last vector element (4 elements of 8 bits).
    localparam logic [1:0] K_LAST = 2'd3;

endpackage

// File: rtl/vector_seq.sv
// ---------------------------------------------------------------------------
// vector_seq
// Control sequencer for a 4 x 8-bit vector unit. Walks VLOAD, VSTORE and
// VADD through the datapath by driving register loads, mux selects and
// memory strobes. All outputs are decoded from the registered state, element
// index and latched op only, so start/op never reach an output
// combinationally.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   operation request, sampled only in IDLE
//   op        in   2-bit op code (VLOAD/VSTORE/VADD/illegal)
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//   err       out  pulses together with done for an illegal op
//   R2Sel     out  R2 source: 0 = RF port 2, 1 = increment
//   R2Ld      out  R2 load enable
//   MemIn     out  memory write-data select (0..3 = X1 byte, 4 = R1)
//   MemRead   out  data-memory read strobe (address from R2)
//   MemWrite  out  data-memory write strobe (address from R2)
//   X1Load    out  X1 source-vector latch enable
//   X2Load    out  X2 source-vector latch enable
//   VoutSel   out  T-register mux: 0 = adders, 1 = memory
//   TLd       out  per-element T register load (bit k loads Tk)
//   VRFWrite  out  vector register file write enable
//   dbg_state out  current FSM state encoding (observation only)
// ---------------------------------------------------------------------------
module vector_seq
    import vector_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       R2Sel,
    output logic       R2Ld,
    output logic [2:0] MemIn,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       X1Load,
    output logic       X2Load,
    output logic       VoutSel,
    output logic [3:0] TLd,
    output logic       VRFWrite,
    output logic [3:0] dbg_state
);

    state_t     r_state;
    logic [1:0] r_k;
    logic [1:0] r_op;

    state_t     w_next_state;
    logic [1:0] w_next_k;

    // Registered state. The op is captured on the accepting edge so that op
    // changes while busy have no effect on the running sequence.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
            r_op    <= OP_VLOAD;
        end else begin
            r_state <= w_next_state;
            r_k     <= w_next_k;
            if (r_state == S_IDLE && start) begin
                r_op <= op;
            end
        end
    end

    // Next-state and output decode. Outputs depend only on r_state, r_k and
    // r_op; start/op only steer the next state out of IDLE.
    always_comb begin
        w_next_state = r_state;
        w_next_k     = r_k;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        err          = 1'b0;
        R2Sel        = 1'b0;
        R2Ld         = 1'b0;
        MemIn        = MEMIN_R1;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        X1Load       = 1'b0;
        X2Load       = 1'b0;
        VoutSel      = 1'b0;
        TLd          = 4'b0000;
        VRFWrite     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_k = 2'd0;
                    case (op)
                        OP_VLOAD,
                        OP_VSTORE: w_next_state = S_BASE;
                        OP_VADD:   w_next_state = S_XLD;
                        default:   w_next_state = S_FIN;
                    endcase
                end
            end

            // Load R2 with the base address from the register file.
            S_BASE: begin
                R2Ld         = 1'b1;
                R2Sel        = 1'b0;
                w_next_state = (r_op == OP_VLOAD) ? S_RD : S_XLD;
            end

            // VSTORE needs only X1; VADD latches both source vectors.
            S_XLD: begin
                X1Load = 1'b1;
                if (r_op == OP_VADD) begin
                    X2Load       = 1'b1;
                    w_next_state = S_TADD;
                end else begin
                    w_next_state = S_WR;
                end
            end

            // Memory returns data one cycle after the read strobe, so the
            // capture into Tk happens in the following CAP state.
            S_RD: begin
                MemRead      = 1'b1;
                w_next_state = S_CAP;
            end

            S_CAP: begin
                VoutSel = 1'b1;
                TLd     = 4'b0001 << r_k;
                R2Ld    = 1'b1;
                R2Sel   = 1'b1;
                if (r_k == K_LAST) begin
                    w_next_k     = 2'd0;
                    w_next_state = S_VWR;
                end else begin
                    w_next_k     = r_k + 2'd1;
                    w_next_state = S_RD;
                end
            end

            S_WR: begin
                MemWrite = 1'b1;
                MemIn    = {1'b0, r_k};
                R2Ld     = 1'b1;
                R2Sel    = 1'b1;
                if (r_k == K_LAST) begin
                    w_next_k     = 2'd0;
                    w_next_state = S_FIN;
                end else begin
                    w_next_k     = r_k + 2'd1;
                end
            end

            // All four byte adders load at once; carries out are dropped.
            S_TADD: begin
                TLd          = 4'b1111;
                VoutSel      = 1'b0;
                w_next_state = S_VWR;
            end

            S_VWR: begin
                VRFWrite     = 1'b1;
                w_next_state = S_FIN;
            end

            S_FIN: begin
                done         = 1'b1;
                err          = (r_op == OP_ILL);
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
                w_next_k     = 2'd0;
            end
        endcase
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_vector_seq.sv
// ---------------------------------------------------------------------------
// tb_vector_seq
// Bench for the vector sequencer. A small behavioural datapath (R2, X1/X2,
// T0..T3, byte memory with one-cycle read latency) is steered by the DUT's
// control outputs. Expected vector-RF writes and memory writes are queued
// when an operation is launched and compared when the DUT strobes them.
// ---------------------------------------------------------------------------
module tb_vector_seq;
    import vector_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;

    always #5 clock = ~clock;

    // ---------------- DUT ----------------
    logic       busy, done, err, R2Sel, R2Ld, MemRead, MemWrite;
    logic       X1Load, X2Load, VoutSel, VRFWrite;
    logic [2:0] MemIn;
    logic [3:0] TLd;
    logic [3:0] dbg_state;

    vector_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .R2Sel     (R2Sel),
        .R2Ld      (R2Ld),
        .MemIn     (MemIn),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .X1Load    (X1Load),
        .X2Load    (X2Load),
        .VoutSel   (VoutSel),
        .TLd       (TLd),
        .VRFWrite  (VRFWrite),
        .dbg_state (dbg_state)
    );

    // All outputs packed; the idle/reset value is everything 0, MemIn = 4.
    logic [17:0] w_outs;
    assign w_outs = {busy, done, err, R2Sel, R2Ld, MemRead, MemWrite, X1Load,
                     X2Load, VoutSel, VRFWrite, TLd, MemIn};
    localparam logic [17:0] OUTS_DEF = 18'd4;

    // ---------------- behavioural datapath ----------------
    logic [7:0]  mem [0:255];
    logic [7:0]  r2;
    logic [31:0] x1, x2;
    logic [7:0]  t [4];
    logic [7:0]  mem_q;
    logic [7:0]  rf_p2;
    logic [31:0] rf_x1, rf_x2;
    logic [7:0]  rf_r1 = 8'hEE;
    logic        pl_we;
    logic [7:0]  pl_addr, pl_data;
    logic [7:0]  wdata;
    logic [31:0] vdataw;

    always_comb begin
        case (MemIn)
            3'd0:    wdata = x1[31:24];
            3'd1:    wdata = x1[23:16];
            3'd2:    wdata = x1[15:8];
            3'd3:    wdata = x1[7:0];
            default: wdata = rf_r1;
        endcase
    end

    assign vdataw = {t[0], t[1], t[2], t[3]};

    always @(posedge clock) begin
        if (R2Ld)    r2 <= R2Sel ? r2 + 8'd1 : rf_p2;
        if (X1Load)  x1 <= rf_x1;
        if (X2Load)  x2 <= rf_x2;
        if (MemRead) mem_q <= mem[r2];
        if (pl_we)         mem[pl_addr] <= pl_data;
        else if (MemWrite) mem[r2] <= wdata;
        for (int k = 0; k < 4; k++) begin
            if (TLd[k]) t[k] <= VoutSel ? mem_q : x1[31-8*k -: 8] + x2[31-8*k -: 8];
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];   // expected vector-RF write data
    logic [31:0] wr_q[$];    // expected {MemIn, address, data} per memory write
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int vrf_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (done) done_cnt++;
            if (VRFWrite) begin
                vrf_cnt++;
                check("vrf_vs_tld", {28'd0, TLd}, 32'd0);
                if (exp_q.size() == 0) check("vrf_unexpected", 32'd1, 32'd0);
                else                   check("vrf_data", vdataw, exp_q.pop_front());
            end
            if (MemWrite) begin
                check("wr_vs_rd", {31'd0, MemRead}, 32'd0);
                if (wr_q.size() == 0) check("memwr_unexpected", 32'd1, 32'd0);
                else                  check("memwr", {13'd0, MemIn, r2, wdata}, wr_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(posedge clock);
        #1 pl_we = 1'b0;
    endtask

    // Launch one operation and follow it to done. With hold set, start stays
    // high and op is scrambled every cycle while the DUT is busy.
    task automatic do_op(input logic [1:0] opc, input int exp_lat, input bit hold);
        int  n;
        bit  seen;
        int  d0;
        d0 = done_cnt;
        @(negedge clock);
        start = 1'b1;
        op    = opc;
        @(posedge clock);
        if (!hold) #1 start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            if (hold) op = 2'($urandom_range(0, 3));
            if (done) begin
                seen = 1'b1;
                check("latency", n, exp_lat);
                check("busy_fin", {31'd0, busy}, 32'd1);
                check("err", {31'd0, err}, {31'd0, (opc == OP_ILL)});
                check("fin_defaults", {17'd0, w_outs[14:0]}, {17'd0, OUTS_DEF[14:0]});
                if (hold) start = 1'b0;
            end else begin
                check("busy", {31'd0, busy}, 32'd1);
                if (opc == OP_VADD) check("vadd_no_mem", {30'd0, MemRead, MemWrite}, 32'd0);
            end
        end
        if (!seen) begin
            check("done_timeout", n, exp_lat);
            start = 1'b0;
        end
        @(negedge clock);
        check("done_pulse_width", {30'd0, done, busy}, 32'd0);
        if (hold) check("one_done", done_cnt - d0, 1);
    endtask

    function automatic logic [31:0] vadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        for (int k = 0; k < 4; k++) s[31-8*k -: 8] = a[31-8*k -: 8] + b[31-8*k -: 8];
        return s;
    endfunction

    task automatic push_store(input logic [7:0] base, input logic [31:0] xv);
        for (int k = 0; k < 4; k++) begin
            wr_q.push_back({13'd0, 3'(k), 8'(base + 8'(k)), xv[31-8*k -: 8]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int d0;
        logic [31:0] a, b;
        logic [7:0]  base;

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        pl_we = 1'b0;
        pl_addr = 8'd0;
        pl_data = 8'd0;
        rf_p2 = 8'd0;
        rf_x1 = 32'd0;
        rf_x2 = 32'd0;

        #1 check("reset_outs", {14'd0, w_outs}, {14'd0, OUTS_DEF});
        repeat (2) @(posedge clock);
        #1 check("reset_outs_held", {14'd0, w_outs}, {14'd0, OUTS_DEF});
        check("reset_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
        reset = 1'b1;

        // Directed VLOAD from base 0x10.
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
        rf_p2 = 8'h10;
        exp_q.push_back(32'h11223344);
        v0 = vrf_cnt;
        do_op(OP_VLOAD, 11, 1'b0);
        check("vload_vrf_once", vrf_cnt - v0, 1);
        check("vload_r2_end", {24'd0, r2}, 32'h14);

        // Directed VSTORE of X1 to base 0x20.
        rf_x1 = 32'hA1B2C3D4;
        rf_p2 = 8'h20;
        push_store(8'h20, 32'hA1B2C3D4);
        do_op(OP_VSTORE, 7, 1'b0);
        check("vstore_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'hA1B2C3D4);

        // Directed VADD with per-byte wrap.
        rf_x1 = 32'h01FF7F80;
        rf_x2 = 32'h01018080;
        exp_q.push_back(32'h0200FF00);
        do_op(OP_VADD, 4, 1'b0);

        // Illegal op.
        d0 = done_cnt;
        do_op(OP_ILL, 1, 1'b0);
        check("ill_done_once", done_cnt - d0, 1);

        // Random VADDs and a random VSTORE.
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            rf_x1 = a;
            rf_x2 = b;
            exp_q.push_back(vadd(a, b));
            do_op(OP_VADD, 4, 1'b0);
        end
        base  = 8'($urandom_range(8'h40, 8'h70));
        rf_x1 = $urandom;
        rf_p2 = base;
        push_store(base, rf_x1);
        do_op(OP_VSTORE, 7, 1'b0);

        // start held high with op scrambling during a VSTORE.
        rf_x1 = 32'h5A6B7C8D;
        rf_p2 = 8'h80;
        push_store(8'h80, 32'h5A6B7C8D);
        do_op(OP_VSTORE, 7, 1'b1);

        // Reset during VLOAD CAP with k = 2.
        poke(8'h30, 8'h01); poke(8'h31, 8'h02); poke(8'h32, 8'h03); poke(8'h33, 8'h04);
        rf_p2 = 8'h30;
        d0 = done_cnt;
        v0 = vrf_cnt;
        @(negedge clock);
        start = 1'b1;
        op    = OP_VLOAD;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (7) @(negedge clock);
        check("cap_k2_state", {28'd0, dbg_state}, {28'd0, S_CAP});
        check("cap_k2_tld", {28'd0, TLd}, 32'h4);
        reset = 1'b0;
        #1;
        check("abort_outs", {14'd0, w_outs}, {14'd0, OUTS_DEF});
        check("abort_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
        repeat (3) @(posedge clock);
        #1 check("abort_outs_held", {14'd0, w_outs}, {14'd0, OUTS_DEF});
        @(posedge clock);
        #1 reset = 1'b1;
        // First rising edge after release accepts this VADD.
        rf_x1 = 32'h10203040;
        rf_x2 = 32'hF0E0D0C0;
        exp_q.push_back(32'h00000000);
        do_op(OP_VADD, 4, 1'b0);
        check("abort_no_done", done_cnt - d0, 1);
        check("abort_vrf_only_vadd", vrf_cnt - v0, 1);

        repeat (2) @(negedge clock);
        check("exp_q_empty", exp_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
